lpc_synth: RTL and testbench

LPC_SYNTH -- requirements
Module: lpc_synth

---
 rtl/lpc_pkg.sv | 35 +++
 rtl/lpc_excite.sv | 54 +++++
 rtl/lpc_synth.sv | 175 +++++++++++++++++
 tb/tb_lpc_synth.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// LPC synthesis shared definitions: filter sizes, Avalon register map,
// FSM state encoding and the output saturation helper.
package lpc_pkg;

   localparam int LPC_ORDER = 10;
   localparam int COEF_W    = 16;
   localparam int ACC_W     = 40;

   localparam logic [15:0] ADDR_PITCH  = 16'd0;
   localparam logic [15:0] ADDR_GAIN   = 16'd1;
   localparam logic [15:0] ADDR_STATUS = 16'd2;
   localparam logic [15:0] BAD_DATA    = 16'hbad;

   localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXCITE,
      ST_MAC,
      ST_OUT
   } state_t;

   function automatic logic [COEF_W-1:0] sat16(
      input logic signed [ACC_W-1:0] x
   );
      if (x > SAT_MAX)
         return 16'h7fff;
      else if (x < SAT_MIN)
         return 16'h8000;
      else
         return x[COEF_W-1:0];
   endfunction

endpackage

// File: rtl/lpc_excite.sv
// Excitation source: pitch-pulse train when voiced; when unvoiced either
// zero or, with LPC_SYNTH_NOISE_EN defined, LFSR noise scaled by gain.
// Ports: clk, rst (sync, active-high), step (EXCITE cycle), voiced,
//        pitch, gain in; e (signed excitation, valid during step) out.
module lpc_excite
   import lpc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              voiced,
   input  logic [COEF_W-1:0] pitch,
   input  logic [COEF_W-1:0] gain,
   output logic [COEF_W-1:0] e
);

   logic [15:0] cnt;
   logic [15:0] period;

   // pitch 0 and 1 both mean an impulse every sample
   assign period = (pitch < 16'd2) ? 16'd1 : pitch;

   // >= (not ==) so a shortened pitch cannot strand the counter
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (step && voiced)
         cnt <= (cnt >= period - 16'd1) ? '0 : cnt + 16'd1;
   end

`ifdef LPC_SYNTH_NOISE_EN
   logic [15:0]        lfsr;
   logic               fb;
   logic signed [31:0] noise;

   // Fibonacci taps 16,14,13,11
   assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge clk) begin
      if (rst)
         lfsr <= 16'hACE1;
      else if (step)
         lfsr <= {lfsr[14:0], fb};
   end

   assign noise = $signed(lfsr) * $signed(gain);

   assign e = voiced ? ((cnt == '0) ? gain : '0)
                     : 16'(noise >>> 15);
`else
   assign e = (voiced && cnt == '0) ? gain : '0;
`endif

endmodule

// File: rtl/lpc_synth.sv
// 10th-order LPC all-pole synthesis filter with Avalon-MM control.
// Ports: clk, rst (sync, active-high), v (sample tick), load, A1..A10,
//        voiced in; y, vout out; Avalon address/read/write/writedata in,
//        readdata out. Optional noise excitation: LPC_SYNTH_NOISE_EN.
module lpc_synth
   import lpc_pkg::*;
#(
   parameter int COEF_FRAC   = 12,
   parameter int RESET_PITCH = 80,
   parameter int RESET_GAIN  = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        v,
   input  logic        load,
   input  logic [15:0] A1,
   input  logic [15:0] A2,
   input  logic [15:0] A3,
   input  logic [15:0] A4,
   input  logic [15:0] A5,
   input  logic [15:0] A6,
   input  logic [15:0] A7,
   input  logic [15:0] A8,
   input  logic [15:0] A9,
   input  logic [15:0] A10,
   input  logic        voiced,
   output logic [15:0] y,
   output logic        vout,
   input  logic [15:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [15:0] writedata,
   output logic [15:0] readdata
);

   state_t state;
   state_t state_nx;

   logic [3:0]               tap;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_sh;
   logic signed [COEF_W-1:0] a_in [LPC_ORDER];
   logic signed [COEF_W-1:0] coef [LPC_ORDER];
   logic signed [COEF_W-1:0] hist [LPC_ORDER];
   logic signed [31:0]       prod;
   logic [COEF_W-1:0]        e;
   logic [COEF_W-1:0]        y_sat;
   logic                     voiced_sh;
   logic                     pending;
   logic                     overrun;
   logic                     copy;
   logic [15:0]              pitch;
   logic [15:0]              gain;

   assign a_in[0] = A1;
   assign a_in[1] = A2;
   assign a_in[2] = A3;
   assign a_in[3] = A4;
   assign a_in[4] = A5;
   assign a_in[5] = A6;
   assign a_in[6] = A7;
   assign a_in[7] = A8;
   assign a_in[8] = A9;
   assign a_in[9] = A10;

   lpc_excite u_excite (
      .clk    (clk),
      .rst    (rst),
      .step   (state == ST_EXCITE),
      .voiced (voiced_sh),
      .pitch  (pitch),
      .gain   (gain),
      .e      (e)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (v) state_nx = ST_EXCITE;
         ST_EXCITE: state_nx = ST_MAC;
         ST_MAC:    if (tap == 4'(LPC_ORDER - 1)) state_nx = ST_OUT;
         ST_OUT:    state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // shadow update only between samples: directly from IDLE, or
   // deferred to the end of OUT when the strobe came mid-sample
   assign copy = (state == ST_IDLE && load) ||
                 (state == ST_OUT && (pending || load));

   assign prod   = coef[tap] * hist[tap];
   assign acc_sh = acc >>> COEF_FRAC;
   assign y_sat  = sat16(acc_sh);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         tap       <= '0;
         y         <= '0;
         vout      <= 1'b0;
         hist      <= '{default: '0};
         coef      <= '{default: '0};
         voiced_sh <= 1'b0;
         pending   <= 1'b0;
      end else begin
         vout <= 1'b0;
         if (copy) begin
            coef      <= a_in;
            voiced_sh <= voiced;
            pending   <= 1'b0;
         end else if (load && state != ST_IDLE) begin
            pending <= 1'b1;
         end
         case (state)
            ST_EXCITE: begin
               acc <= ACC_W'($signed(e)) <<< COEF_FRAC;
               tap <= '0;
            end
            ST_MAC: begin
               acc <= acc - ACC_W'(prod);
               tap <= tap + 4'd1;
            end
            ST_OUT: begin
               y       <= y_sat;
               vout    <= 1'b1;
               hist[0] <= y_sat;
               for (int i = 1; i < LPC_ORDER; i++)
                  hist[i] <= hist[i-1];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pitch    <= 16'(RESET_PITCH);
         gain     <= 16'(RESET_GAIN);
         overrun  <= 1'b0;
         readdata <= '0;
      end else begin
         if (write) begin
            if (address == ADDR_PITCH)
               pitch <= writedata;
            else if (address == ADDR_GAIN)
               gain <= writedata;
         end
         readdata <= '0;
         if (read) begin
            if (address == ADDR_PITCH)
               readdata <= pitch;
            else if (address == ADDR_GAIN)
               readdata <= gain;
            else if (address == ADDR_STATUS)
               readdata <= {15'b0, overrun};
            else
               readdata <= BAD_DATA;
         end
         // a dropped tick wins over a same-cycle status read
         if (v && state != ST_IDLE)
            overrun <= 1'b1;
         else if (read && address == ADDR_STATUS)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lpc_synth.sv
// Testbench for lpc_synth: scoreboard of expected samples and strobe
// times, drained by a vout monitor; scenario tasks run in sequence.
module tb_lpc_synth;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        v = 1'b0;
   logic        load = 1'b0;
   logic [15:0] a_in [10];
   logic        voiced = 1'b0;
   logic [15:0] y;
   logic        vout;
   logic [15:0] address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [15:0] writedata = '0;
   logic [15:0] readdata;

   typedef struct {
      logic [15:0] y;
      int          cyc;
   } exp_t;

   exp_t sb [$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   vout_cnt = 0;

   lpc_synth dut (
      .clk       (clk),
      .rst       (rst),
      .v         (v),
      .load      (load),
      .A1        (a_in[0]),
      .A2        (a_in[1]),
      .A3        (a_in[2]),
      .A4        (a_in[3]),
      .A5        (a_in[4]),
      .A6        (a_in[5]),
      .A7        (a_in[6]),
      .A8        (a_in[7]),
      .A9        (a_in[8]),
      .A10       (a_in[9]),
      .voiced    (voiced),
      .y         (y),
      .vout      (vout),
      .address   (address),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // every strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (vout) begin
         exp_t ex;
         vout_cnt++;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_vout cyc=%0d y=%0d", cyc, $signed(y));
         end else begin
            ex = sb.pop_front();
            if (y !== ex.y || cyc != ex.cyc) begin
               fails++;
               $display("FAIL sample y=%0d want %0d cyc=%0d want %0d",
                        $signed(y), $signed(ex.y), cyc, ex.cyc);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] a, output logic [15:0] d);
      @(negedge clk);
      address = a;
      read = 1'b1;
      @(negedge clk);
      d = readdata;
      read = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      address = a;
      writedata = d;
      write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] a1, input logic vc);
      @(negedge clk);
      for (int i = 0; i < 10; i++) a_in[i] = '0;
      a_in[0] = a1;
      voiced = vc;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // v is sampled on the next posedge (cyc+1); vout follows 12 edges later
   task automatic send(input logic [15:0] ey, input int gap);
      @(negedge clk);
      v = 1'b1;
      sb.push_back('{y: ey, cyc: cyc + 13});
      @(negedge clk);
      v = 1'b0;
      repeat (gap - 2) @(negedge clk);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain left=%0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      logic [15:0] d;
      do_reset();
      tests += 3;
      if (y !== 16'd0) begin
         fails++; $display("FAIL reset_y got %0d want 0", y);
      end
      if (vout !== 1'b0) begin
         fails++; $display("FAIL reset_vout got %0b want 0", vout);
      end
      if (readdata !== 16'd0) begin
         fails++; $display("FAIL reset_rd got %0h want 0", readdata);
      end
      do_read(16'd0, d);
      tests++;
      if (d !== 16'd80) begin
         fails++; $display("FAIL rd_pitch got %0d want 80", d);
      end
      do_read(16'd1, d);
      tests++;
      if (d !== 16'd4096) begin
         fails++; $display("FAIL rd_gain got %0d want 4096", d);
      end
      do_read(16'd7, d);
      tests++;
      if (d !== 16'hbad) begin
         fails++; $display("FAIL rd_bad got %0h want bad", d);
      end
      @(negedge clk);
      tests++;
      if (readdata !== 16'd0) begin
         fails++; $display("FAIL rd_idle got %0h want 0", readdata);
      end
   endtask

   task automatic test_pitch_train();
      do_reset();
      do_write(16'd0, 16'd4);
      do_write(16'd1, 16'd1000);
      do_load(16'd0, 1'b1);
      for (int k = 0; k < 8; k++)
         send((k % 4 == 0) ? 16'd1000 : 16'd0, 20);
      wait_drain();
   endtask

   task automatic test_decay();
      do_reset();
      do_write(16'd0, 16'd100);
      do_write(16'd1, 16'd4096);
      do_load(-16'sd2048, 1'b1);
      for (int k = 0; k < 8; k++)
         send(16'(4096 >> k), 16);
      wait_drain();
   endtask

   task automatic test_saturate();
      do_reset();
      do_write(16'd0, 16'd100);
      do_write(16'd1, 16'd30000);
      do_load(-16'sd8192, 1'b1);
      send(16'd30000, 16);
      for (int k = 0; k < 5; k++)
         send(16'd32767, 16);
      wait_drain();
   endtask

   task automatic test_load_mid();
      do_reset();
      do_write(16'd0, 16'd100);
      do_load(-16'sd2048, 1'b1);
      send(16'd4096, 16);
      @(negedge clk);
      v = 1'b1;
      sb.push_back('{y: 16'd2048, cyc: cyc + 13});
      @(negedge clk);
      v = 1'b0;
      repeat (3) @(negedge clk);
      a_in[0] = -16'sd1024;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (12) @(negedge clk);
      send(16'd512, 16);
      send(16'd128, 16);
      wait_drain();
   endtask

   task automatic test_overrun();
      logic [15:0] d;
      int base;
      do_reset();
      base = vout_cnt;
      @(negedge clk);
      v = 1'b1;
      sb.push_back('{y: 16'd0, cyc: cyc + 13});
      @(negedge clk);
      v = 1'b0;
      repeat (4) @(negedge clk);
      v = 1'b1;
      @(negedge clk);
      v = 1'b0;
      wait_drain();
      repeat (20) @(negedge clk);
      tests++;
      if (vout_cnt - base != 1) begin
         fails++;
         $display("FAIL drop_count got %0d want 1", vout_cnt - base);
      end
      do_read(16'd2, d);
      tests++;
      if (d !== 16'd1) begin
         fails++; $display("FAIL ovr_set got %0d want 1", d);
      end
      do_read(16'd2, d);
      tests++;
      if (d !== 16'd0) begin
         fails++; $display("FAIL ovr_clr got %0d want 0", d);
      end
   endtask

   task automatic test_unvoiced();
      do_reset();
      do_load(-16'sd2048, 1'b0);
      for (int k = 0; k < 3; k++)
         send(16'd0, 16);
      wait_drain();
   endtask

   task automatic test_reset_abort();
      int base;
      do_reset();
      do_load(16'd0, 1'b1);
      base = vout_cnt;
      @(negedge clk);
      v = 1'b1;
      @(negedge clk);
      v = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      tests += 2;
      if (vout_cnt != base) begin
         fails++;
         $display("FAIL abort_vout got %0d want 0", vout_cnt - base);
      end
      if (y !== 16'd0) begin
         fails++; $display("FAIL abort_y got %0d want 0", y);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      do_reset();
      do_write(16'd0, 16'd2);
      do_write(16'd1, 16'd500);
      do_load(16'd0, 1'b1);
      for (int k = 0; k < 4; k++)
         send((k % 2 == 0) ? 16'd500 : 16'd0, 13);
      wait_drain();
      do_read(16'd2, d);
      tests++;
      if (d !== 16'd0) begin
         fails++; $display("FAIL b2b_ovr got %0d want 0", d);
      end
   endtask

   initial begin
      for (int i = 0; i < 10; i++) a_in[i] = '0;
      test_reset();
      test_pitch_train();
      test_decay();
      test_saturate();
      test_load_mid();
      test_overrun();
      test_unvoiced();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
